// File: rtl/sync_filter_edge_pkg.sv
// Shared constants and types for the multi-bit synchronizer / glitch filter / edge detector.
// Holds the minimum legal chain depth and the per-bit filter decision type.
package sync_filter_edge_pkg;

  localparam int STAGES_MIN = 2;

  // Per-bit decision taken on each clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_FOLLOW = 2'd1,
    ACT_COUNT  = 2'd2
  } filt_act_e;

  function automatic bit stages_ok(input int stages);
    return stages >= STAGES_MIN;
  endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One channel of the filter: stability counter, filtered level flop and rise/fall pulse flops.
// edge_next exposes the combinational change so the top can register a summary flag in the same cycle.
module sync_filter_bit
  import sync_filter_edge_pkg::*;
#(
  parameter int   FILTER_W  = 4,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s,
  input  logic                filter_en,
  input  logic [FILTER_W-1:0] filter_len,
  output logic                out,
  output logic                rise,
  output logic                fall,
  output logic                edge_next
);

  logic [FILTER_W-1:0] cnt;
  logic [FILTER_W-1:0] cnt_next;
  logic                out_next;
  filt_act_e           act;

  // A lowered filter_len takes effect at once because of the >= compare;
  // cnt only counts while below filter_len, so it can never wrap.
  always_comb begin
    act = ACT_HOLD;
    if (!filter_en || ((s != out) && (cnt >= filter_len))) begin
      act = ACT_FOLLOW;
    end else if (s != out) begin
      act = ACT_COUNT;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    out_next = out;
    cnt_next = '0;
    unique case (act)
      ACT_FOLLOW: out_next = s;
      ACT_COUNT:  cnt_next = cnt + 1'b1;
      default:    ;
    endcase
  end

  assign edge_next = out_next ^ out;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      out  <= RESET_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      out  <= out_next;
      rise <= out_next & ~out;
      fall <= ~out_next & out;
    end
  end

endmodule

// File: rtl/sync_filter_edge.sv
// Multi-bit CDC synchronizer with per-bit programmable glitch filter and rise/fall edge pulses.
// Top level: the flop chain, the per-bit filter instances and the registered change summary.
module sync_filter_edge
  import sync_filter_edge_pkg::*;
#(
  parameter int          DW        = 32,
  parameter int          STAGES    = 3,
  parameter int          FILTER_W  = 4,
  parameter logic [DW-1:0] RESET_VAL = {DW{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DW-1:0]       in,
  input  logic                filter_en,
  input  logic [FILTER_W-1:0] filter_len,
  output logic [DW-1:0]       out,
  output logic [DW-1:0]       rise,
  output logic [DW-1:0]       fall,
  output logic                changed
);

  if (!stages_ok(STAGES)) begin : g_stages_check
    $error("sync_filter_edge: STAGES must be >= STAGES_MIN");
  end

  logic [STAGES-1:0][DW-1:0] sync_q;
  logic [DW-1:0]             s;
  logic [DW-1:0]             edge_next;

  // NOTE: every chain stage is reset to the same value as out, so reset release never fires an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= RESET_VAL;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[STAGES-1];

  for (genvar i = 0; i < DW; i++) begin : g_bit
    sync_filter_bit #(
      .FILTER_W  (FILTER_W),
      .RESET_BIT (RESET_VAL[i])
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .s          (s[i]),
      .filter_en  (filter_en),
      .filter_len (filter_len),
      .out        (out[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .edge_next  (edge_next[i])
    );
  end

  // Registered from the next-state edges so it lines up with the rise/fall pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) changed <= 1'b0;
    else       changed <= |edge_next;
  end

endmodule

// File: tb/tb_sync_filter_edge.sv
// Scoreboard bench for sync_filter_edge: stimulus pushes expected change events with their
// cycle, a monitor pops and compares whenever the DUT flags a change.
module tb_sync_filter_edge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_bus;
  logic       filter_en;
  logic [3:0] filter_len;
  logic [7:0] out, rise, fall;
  logic       changed;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         at;
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
  } ev_t;

  ev_t exp_q[$];

  sync_filter_edge #(
    .DW        (8),
    .STAGES    (3),
    .FILTER_W  (4),
    .RESET_VAL (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in_bus),
    .filter_en  (filter_en),
    .filter_len (filter_len),
    .out        (out),
    .rise       (rise),
    .fall       (fall),
    .changed    (changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int at, input logic [7:0] o, input logic [7:0] r,
                           input logic [7:0] f);
    ev_t e;
    e.at = at; e.out = o; e.rise = r; e.fall = f;
    exp_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      check("missed_event_cycle", cyc, exp_q[0].at);
      void'(exp_q.pop_front());
    end
    if (changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_changed", {31'd0, changed}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.at);
        check("event_out", out, e.out);
        check("event_rise", rise, e.rise);
        check("event_fall", fall, e.fall);
      end
    end else begin
      check("pulse_without_changed", rise | fall, 32'd0);
    end
  end

  int t;

  initial begin
    reset      = 1'b1;
    in_bus     = 8'hFF;
    filter_en  = 1'b0;
    filter_len = 4'd0;

    // 1: reset state with in held high, then release
    repeat (2) @(negedge clk);
    check("reset_out", out, 8'h00);
    check("reset_rise", rise, 8'h00);
    check("reset_changed", changed, 1'b0);
    @(negedge clk); reset = 1'b0; t = cyc;
    expect_ev(t + 4, 8'hFF, 8'hFF, 8'h00);
    repeat (8) @(negedge clk);

    // 2: unfiltered latency, fall and rise on single bits
    in_bus = 8'h00; t = cyc; expect_ev(t + 4, 8'h00, 8'h00, 8'hFF);
    repeat (8) @(negedge clk);
    in_bus = 8'h01; t = cyc; expect_ev(t + 4, 8'h01, 8'h01, 8'h00);
    repeat (8) @(negedge clk);
    in_bus = 8'h00; t = cyc; expect_ev(t + 4, 8'h00, 8'h00, 8'h01);
    repeat (8) @(negedge clk);

    // 3: glitch filter with filter_len=3
    filter_en = 1'b1; filter_len = 4'd3;
    repeat (3) @(negedge clk);
    in_bus = 8'h20;
    repeat (3) @(negedge clk);
    in_bus = 8'h00;
    repeat (12) @(negedge clk);
    in_bus = 8'h20; t = cyc; expect_ev(t + 7, 8'h20, 8'h20, 8'h00);
    repeat (4) @(negedge clk);
    in_bus = 8'h00; expect_ev(t + 11, 8'h00, 8'h00, 8'h20);
    repeat (12) @(negedge clk);

    // 4: simultaneous rise and fall
    filter_en = 1'b0; filter_len = 4'd0;
    repeat (2) @(negedge clk);
    in_bus = 8'h02; t = cyc; expect_ev(t + 4, 8'h02, 8'h02, 8'h00);
    repeat (8) @(negedge clk);
    in_bus = 8'h01; t = cyc; expect_ev(t + 4, 8'h01, 8'h01, 8'h02);
    repeat (8) @(negedge clk);
    in_bus = 8'h00; t = cyc; expect_ev(t + 4, 8'h00, 8'h00, 8'h01);
    repeat (8) @(negedge clk);

    // 5: reset mid-count with filter_len=7
    in_bus = 8'h80; t = cyc; expect_ev(t + 4, 8'h80, 8'h80, 8'h00);
    repeat (8) @(negedge clk);
    filter_en = 1'b1; filter_len = 4'd7;
    repeat (2) @(negedge clk);
    in_bus = 8'h00;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_out", out, 8'h00);
    check("midreset_rise_fall", rise | fall, 8'h00);
    check("midreset_changed", changed, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    in_bus = 8'h08;
    repeat (7) @(negedge clk);
    in_bus = 8'h00;
    repeat (12) @(negedge clk);
    in_bus = 8'h08; t = cyc; expect_ev(t + 11, 8'h08, 8'h08, 8'h00);
    repeat (8) @(negedge clk);
    in_bus = 8'h00; expect_ev(t + 19, 8'h00, 8'h00, 8'h08);
    repeat (14) @(negedge clk);

    // 6: filter_len lowered mid-count, then filter_en dropped mid-count
    filter_len = 4'd10;
    repeat (2) @(negedge clk);
    in_bus = 8'h10; t = cyc;
    repeat (8) @(negedge clk);
    filter_len = 4'd2; expect_ev(t + 9, 8'h10, 8'h10, 8'h00);
    repeat (4) @(negedge clk);
    filter_len = 4'd10;
    repeat (2) @(negedge clk);
    in_bus = 8'h00; t = cyc;
    repeat (8) @(negedge clk);
    filter_en = 1'b0; expect_ev(t + 9, 8'h00, 8'h00, 8'h10);
    repeat (10) @(negedge clk);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
